// File: rtl/perf_pkg.sv
// Shared definitions for the performance statistics unit: FSM states and counter slots.
package perf_pkg;

  localparam int NUM_CNT = 6;

  localparam logic [2:0] IDX_CYCLES = 3'd0;
  localparam logic [2:0] IDX_INST   = 3'd1;
  localparam logic [2:0] IDX_DHIT   = 3'd2;
  localparam logic [2:0] IDX_IHIT   = 3'd3;
  localparam logic [2:0] IDX_DREQ   = 3'd4;
  localparam logic [2:0] IDX_IREQ   = 3'd5;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/perf_counter.sv
// Single event counter: +1 per cycle when en and not frozen; PERF_SAT_EN selects saturate vs wrap.
// Latency 1 cycle (count reflects events up to the previous edge); no backpressure.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && !freeze) begin
`ifdef PERF_SAT_EN
      if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
`else
      count <= count + 1'b1;
`endif
    end
  end

endmodule

// File: rtl/perf_stats_unit.sv
// Counts pipeline/cache events until halt, then streams six counters out over valid/ready (PERF_SAT_EN: saturate).
// First word one cycle after halt; each word held until dump_ready; done after the last word is accepted.
module perf_stats_unit
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [2:0]       dump_idx,
  output logic [CNT_W-1:0] dump_data,
  output logic             dump_last,
  output logic             done
);

  state_t           state, state_nxt;
  logic [2:0]       idx_nxt;
  logic             freeze;
  logic [NUM_CNT-1:0] en;
  logic [CNT_W-1:0] counts [NUM_CNT];

  assign freeze = (state != RUN);

  always_comb begin
    en             = '0;
    en[IDX_CYCLES] = 1'b1;
    en[IDX_INST]   = halt | reg_write | mem_write;
    en[IDX_DHIT]   = dcache_hit;
    en[IDX_IHIT]   = icache_hit;
    en[IDX_DREQ]   = dcache_req;
    en[IDX_IREQ]   = icache_req;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .en     (en[g]),
      .freeze (freeze),
      .count  (counts[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      dump_idx <= 3'd0;
    end else begin
      state    <= state_nxt;
      dump_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = dump_idx;
    case (state)
      RUN: begin
        if (halt) begin
          state_nxt = DUMP;
          idx_nxt   = 3'd0;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (dump_idx == IDX_IREQ) state_nxt = DONE;
          else                      idx_nxt   = 3'(dump_idx + 3'd1);
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Counters are frozen flops during DUMP and dump_idx is a flop, so the data
  // word has no combinational path from any input.
  always_comb begin
    dump_data = '0;
    case (dump_idx)
      3'd0:    dump_data = counts[0];
      3'd1:    dump_data = counts[1];
      3'd2:    dump_data = counts[2];
      3'd3:    dump_data = counts[3];
      3'd4:    dump_data = counts[4];
      3'd5:    dump_data = counts[5];
      default: dump_data = '0;
    endcase
  end

  assign dump_valid = (state == DUMP);
  assign dump_last  = dump_valid && (dump_idx == IDX_IREQ);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_perf_stats_unit.sv
// Randomized bench for perf_stats_unit: a 32-bit and a 4-bit instance share stimulus and are
// checked against an event-level reference model (honours PERF_SAT_EN).
module tb_perf_stats_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reg_write = 1'b0, mem_write = 1'b0, halt = 1'b0;
  logic icache_req = 1'b0, icache_hit = 1'b0, dcache_req = 1'b0, dcache_hit = 1'b0;
  logic dump_ready = 1'b0;

  logic        va, vb, la, lb, dna, dnb;
  logic [2:0]  ia, ib;
  logic [31:0] da;
  logic [3:0]  db;

  int errors = 0;
  int checks = 0;

  longint unsigned e32 [6];
  longint unsigned e4  [6];
  bit mrun = 1'b1;

  perf_stats_unit #(.CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .reg_write(reg_write), .mem_write(mem_write), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .dump_valid(va), .dump_ready(dump_ready), .dump_idx(ia), .dump_data(da), .dump_last(la), .done(dna)
  );

  perf_stats_unit #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .reg_write(reg_write), .mem_write(mem_write), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .dump_valid(vb), .dump_ready(dump_ready), .dump_idx(ib), .dump_data(db), .dump_last(lb), .done(dnb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned bump(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
`ifdef PERF_SAT_EN
    return (v < mx) ? v + 64'd1 : v;
`else
    return (v + 64'd1) & mx;
`endif
  endfunction

  task automatic model_inc(input int i);
    e32[i] = bump(e32[i], 32);
    e4[i]  = bump(e4[i], 4);
  endtask

  // Apply the reference model for the inputs currently driven, then advance one clock.
  task automatic cycle();
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        e32[i] = 0;
        e4[i]  = 0;
      end
      mrun = 1'b1;
    end else if (mrun) begin
      model_inc(0);
      if (halt || reg_write || mem_write) model_inc(1);
      if (dcache_hit) model_inc(2);
      if (icache_hit) model_inc(3);
      if (dcache_req) model_inc(4);
      if (icache_req) model_inc(5);
      if (halt) mrun = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    reg_write = 0; mem_write = 0; halt = 0;
    icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic rand_ev(input bit with_halt);
    reg_write  = 1'($urandom_range(0, 1));
    mem_write  = 1'($urandom_range(0, 1));
    icache_req = 1'($urandom_range(0, 1));
    icache_hit = 1'($urandom_range(0, 1));
    dcache_req = 1'($urandom_range(0, 1));
    dcache_hit = 1'($urandom_range(0, 1));
    halt       = with_halt ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid_a"}, va, 0);
    chk({tag, "_valid_b"}, vb, 0);
    chk({tag, "_done"}, dna, 0);
    chk({tag, "_idx"}, ia, 0);
    chk({tag, "_last"}, la, 0);
  endtask

  // Reset cycles carry random events, including halt, which must all be ignored.
  task automatic do_reset();
    rst = 1;
    rand_ev(1'b0);
    halt = 1;
    cycle();
    rand_ev(1'b1);
    cycle();
    rst = 0;
    clear_ev();
  endtask

  task automatic run_then_halt(input int n);
    for (int i = 0; i < n; i++) begin
      rand_ev(1'b0);
      cycle();
    end
    rand_ev(1'b0);
    halt = 1;
    cycle();
    clear_ev();
  endtask

  // pat 0: ready held high; pat 1: ready toggles 0,1,... abort_at >= 0 resets at that word.
  task automatic do_dump(input string tag, input int pat, input int abort_at);
    int k = 0;
    int n = 0;
    while (k < 6 && n < 40) begin
      dump_ready = (pat == 0) ? 1'b1 : (n % 2 == 1);
      rand_ev(1'b1);
      chk({tag, "_valid_a"}, va, 1);
      chk({tag, "_valid_b"}, vb, 1);
      chk({tag, "_idx_a"}, ia, 64'(k));
      chk({tag, "_idx_b"}, ib, 64'(k));
      chk({tag, "_data32"}, da, e32[k]);
      chk({tag, "_data4"}, db, e4[k]);
      chk({tag, "_last"}, la, 64'(k == 5));
      chk({tag, "_done_early"}, dna, 0);
      if (k == abort_at) begin
        rst = 1;
        cycle();
        rst = 0;
        clear_ev();
        dump_ready = 0;
        check_idle({tag, "_abort"});
        return;
      end
      cycle();
      n++;
      if (dump_ready) k++;
    end
    chk({tag, "_words"}, 64'(k), 6);
    chk({tag, "_valid_fall"}, va, 0);
    chk({tag, "_done_a"}, dna, 1);
    chk({tag, "_done_b"}, dnb, 1);
    if (pat == 0) chk({tag, "_done_lat"}, 64'(n + 1), 7);
    rand_ev(1'b1);
    cycle();
    cycle();
    chk({tag, "_done_hold"}, dna, 1);
    chk({tag, "_valid_stay0"}, va, 0);
    clear_ev();
    dump_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_idle("reset");

    // 10 writeback cycles then halt
    for (int i = 0; i < 10; i++) begin
      reg_write = 1;
      cycle();
    end
    reg_write = 0;
    halt = 1;
    cycle();
    clear_ev();
    chk("s1_word0", da, 11);
    do_dump("s1", 0, -1);

    // simultaneous reg_write/mem_write/halt after idle
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    reg_write = 1; mem_write = 1; halt = 1;
    cycle();
    clear_ev();
    chk("s2_word0", da, 4);
    do_dump("s2", 0, -1);

    // icache req every cycle, hit on alternate cycles
    do_reset();
    for (int i = 0; i < 8; i++) begin
      icache_req = 1;
      icache_hit = (i % 2 == 0);
      cycle();
    end
    icache_req = 1; icache_hit = 0; halt = 1;
    cycle();
    clear_ev();
    do_dump("s3", 1, -1);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      run_then_halt(int'($urandom_range(5, 40)));
      do_dump("s4", r % 2, -1);
    end

    // reset mid-dump, then a halt straight away
    do_reset();
    run_then_halt(12);
    do_dump("s5", 0, 2);
    halt = 1;
    cycle();
    clear_ev();
    chk("s5_word0", da, 1);
    do_dump("s5b", 0, -1);

    // narrow-counter overflow: 20 instruction events including the halt
    do_reset();
    for (int i = 0; i < 19; i++) begin
      reg_write = 1;
      cycle();
    end
    reg_write = 0;
    halt = 1;
    cycle();
    clear_ev();
`ifdef PERF_SAT_EN
    chk("s6_word0_sat", db, 15);
`else
    chk("s6_word0_wrap", db, 4);
`endif
    do_dump("s6", 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_stats_unit.md
PERF_STATS_UNIT -- requirements
Module: perf_stats_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter and dump word width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port reg_write  input  1  writeback-stage register write this cycle.
REQ-005 SHALL have port mem_write  input  1  memory-stage store this cycle.
REQ-006 SHALL have port halt  input  1  halt instruction in writeback this cycle.
REQ-007 SHALL have port icache_req, icache_hit, dcache_req, dcache_hit  input  1 each  cache event strobes.
REQ-008 SHALL have port dump_valid  output  1  dump word presented.
REQ-009 SHALL have port dump_ready  input  1  consumer accepts dump word.
REQ-010 SHALL have port dump_idx  output  3  index of presented word, 0..5.
REQ-011 SHALL have port dump_data  output  CNT_W  counter value for dump_idx.
REQ-012 SHALL have port dump_last  output  1  high with word 5.
REQ-013 SHALL have port done  output  1  all six words accepted.

Function
REQ-014 SHALL keep six counters: 0 cycles, 1 inst, 2 dcache_hit, 3 icache_hit, 4 dcache_req, 5 icache_req.
REQ-015 SHALL use FSM states RUN, DUMP, DONE; RUN after reset.
REQ-016 In RUN, cycles SHALL increment every cycle, including the halt cycle.
REQ-017 In RUN, inst SHALL increment by exactly 1 when (halt | reg_write | mem_write), even if several are high together.
REQ-018 In RUN, each cache counter SHALL increment by 1 when its strobe is high; hit without req still counts.
REQ-019 Halt in RUN SHALL apply that cycle's increments, then enter DUMP next cycle with idx 0.
REQ-020 In DUMP and DONE all counters SHALL freeze; event inputs, including further halt, SHALL be ignored.
REQ-021 In DUMP, dump_valid SHALL be 1, and dump_data SHALL be counter[dump_idx], registered output.
REQ-022 A word SHALL transfer when dump_valid & dump_ready; idx SHALL advance by 1 the next cycle; data/idx SHALL stay stable while ready is low.
REQ-023 Transfer of idx 5 (dump_last=1) SHALL move FSM to DONE; dump_valid SHALL fall the next cycle.
REQ-024 In DONE, done SHALL be 1 and remain until reset; dump_valid 0.
REQ-025 First word SHALL be presented one cycle after the halt cycle; with ready held high, done SHALL assert 7 cycles after halt.

Reset
REQ-026 rst SHALL zero all counters, dump_idx, dump_valid, dump_last, done, and force RUN.
REQ-027 rst SHALL take priority over every event, including halt in the same cycle; no counting occurs on reset cycles.
REQ-028 rst during DUMP or DONE SHALL abort the dump with no further words.

Configuration
REQ-029 Macro PERF_SAT_EN defined: every counter SHALL saturate at 2^CNT_W-1.
REQ-030 Macro PERF_SAT_EN undefined: every counter SHALL wrap modulo 2^CNT_W.

Structure
REQ-031 Shared package perf_pkg SHALL hold the FSM state typedef, counter index constants 0..5, and NUM_CNT=6.
REQ-032 One sub-module perf_counter SHALL be instantiated six times, with ports clk, rst, en, freeze, and count, and with PERF_SAT_EN handled inside it.

Verification
REQ-033 Reset, then 10 cycles with reg_write=1, then halt: dump gives cycles=11, inst=11, other counters 0, and done at halt+7.
REQ-034 Same cycle reg_write=mem_write=halt=1 after 3 idle cycles: inst=1, cycles=4.
REQ-035 icache_req every cycle with icache_hit on alternate cycles for 8 cycles, then halt: icache_req=9, icache_hit=4 or 5 per the stimulus phase, checked exactly.
REQ-036 dump_ready toggles 0,1,0,1 during dump: each word is held stable while ready is low, idx sequence is 0..5 with no skips, and dump_last coincides with idx 5.
REQ-037 rst asserted at dump idx 2: dump_valid is 0 the next cycle, counters are 0, the FSM is in RUN, and a following halt dumps cycles=1.
REQ-038 CNT_W=4: 20 event cycles give inst=15 with PERF_SAT_EN defined and inst=4 without it.
